// File: rtl/codec_init_seq_if.sv
// Control and pad-facing signals of the codec boot sequencer.
// The sequencer uses the slave view; top-level control logic uses the master view.
interface codec_init_seq_if;
   logic       start;
   logic       sda_in;
   logic       scl_oe;
   logic       sda_oe;
   logic       busy;
   logic       done;
   logic       err;
   logic [2:0] idx;

   modport slave (
      input  start, sda_in,
      output scl_oe, sda_oe, busy, done, err, idx
   );

   modport master (
      output start, sda_in,
      input  scl_oe, sda_oe, busy, done, err, idx
   );
endinterface

// File: rtl/codec_init_seq.sv
// Open-drain I2C master that writes the fixed five-entry codec register table after start.
// Every bus phase change is aligned to a quarter-bit tick derived from clk.
//
// state   | meaning
// --------+-------------------------------------------------------------
// S_IDLE  | bus released, waiting for start
// S_START | q0 SDA low with SCL high, q1 SCL low
// S_BIT   | shift one data bit: q0 drive SDA, q1 release SCL, q3 pull SCL
// S_ACK   | release SDA, clock the ack bit, sample SDA on q2
// S_STOP  | q0 SDA low, q1 release SCL, q2 release SDA
// S_GAP   | bus released for GAP clk cycles before the next write
// S_FIN   | publish done/err and drop busy
module codec_init_seq #(
   parameter int         QDIV = 125,
   parameter int         GAP  = 20000,
   parameter logic [6:0] ADDR = 7'h1A
) (
   input  logic            clk,
   input  logic            reset,
   codec_init_seq_if.slave bus
);
   localparam int TW = $clog2(QDIV);
   localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

   typedef enum logic [2:0] {
      S_IDLE, S_START, S_BIT, S_ACK, S_STOP, S_GAP, S_FIN
   } state_t;

   state_t          state, state_nxt;
   logic [TW-1:0]   tcnt;
   logic            tick, tick_clr;
   logic [1:0]      q, q_nxt;
   logic [2:0]      bit_n, bit_nxt;
   logic [1:0]      byte_n, byte_nxt;
   logic [2:0]      idx_r, idx_nxt;
   logic            nack, nack_nxt;
   logic [GW-1:0]   gap_cnt, gap_nxt;
   logic            scl_r, scl_nxt;
   logic            sda_r, sda_nxt;
   logic            busy_r, busy_nxt;
   logic            done_r, done_nxt;
   logic            err_r, err_nxt;
   logic [1:0]      sda_sync;
   logic [7:0]      cur_byte;

   // Table entries are {reg[6:0], dat[8:0]} so the two payload bytes fall out as slices.
   function automatic logic [7:0] rom_byte(input logic [2:0] i, input logic [1:0] b);
      logic [15:0] e;
      case (i)
         3'd0:    e = {7'h08, 9'h023};
         3'd1:    e = {7'h06, 9'h000};
         3'd2:    e = {7'h07, 9'h040};
         3'd3:    e = {7'h09, 9'h001};
         default: e = {7'h02, 9'h17F};
      endcase
      case (b)
         2'd0:    rom_byte = {ADDR, 1'b0};
         2'd1:    rom_byte = e[15:8];
         default: rom_byte = e[7:0];
      endcase
   endfunction

   assign tick     = (tcnt == TW'(QDIV - 1));
   assign cur_byte = rom_byte(idx_r, byte_n);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         tcnt     <= '0;
         sda_sync <= 2'b11;
      end else begin
         tcnt     <= (tick_clr || tick) ? '0 : tcnt + 1'b1;
         sda_sync <= {sda_sync[0], bus.sda_in};
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= S_IDLE;
         q       <= 2'd0;
         bit_n   <= 3'd7;
         byte_n  <= 2'd0;
         idx_r   <= 3'd0;
         nack    <= 1'b0;
         gap_cnt <= '0;
         scl_r   <= 1'b0;
         sda_r   <= 1'b0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
         err_r   <= 1'b0;
      end else begin
         state   <= state_nxt;
         q       <= q_nxt;
         bit_n   <= bit_nxt;
         byte_n  <= byte_nxt;
         idx_r   <= idx_nxt;
         nack    <= nack_nxt;
         gap_cnt <= gap_nxt;
         scl_r   <= scl_nxt;
         sda_r   <= sda_nxt;
         busy_r  <= busy_nxt;
         done_r  <= done_nxt;
         err_r   <= err_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      q_nxt     = q;
      bit_nxt   = bit_n;
      byte_nxt  = byte_n;
      idx_nxt   = idx_r;
      nack_nxt  = nack;
      gap_nxt   = gap_cnt;
      scl_nxt   = scl_r;
      sda_nxt   = sda_r;
      busy_nxt  = busy_r;
      done_nxt  = done_r;
      err_nxt   = err_r;
      tick_clr  = 1'b0;

      case (state)
         S_IDLE: begin
            scl_nxt = 1'b0;
            sda_nxt = 1'b0;
            if (bus.start && !busy_r) begin
               busy_nxt  = 1'b1;
               done_nxt  = 1'b0;
               err_nxt   = 1'b0;
               idx_nxt   = 3'd0;
               nack_nxt  = 1'b0;
               q_nxt     = 2'd0;
               tick_clr  = 1'b1;
               state_nxt = S_START;
            end
         end

         S_START: begin
            if (tick) begin
               if (q == 2'd0) begin
                  sda_nxt = 1'b1;
                  q_nxt   = 2'd1;
               end else begin
                  scl_nxt   = 1'b1;
                  q_nxt     = 2'd0;
                  byte_nxt  = 2'd0;
                  bit_nxt   = 3'd7;
                  state_nxt = S_BIT;
               end
            end
         end

         S_BIT: begin
            if (tick) begin
               q_nxt = q + 2'd1;
               case (q)
                  2'd0: sda_nxt = ~cur_byte[bit_n];
                  2'd1: scl_nxt = 1'b0;
                  2'd3: begin
                     scl_nxt = 1'b1;
                     if (bit_n == 3'd0) state_nxt = S_ACK;
                     else               bit_nxt   = bit_n - 3'd1;
                  end
                  default: ;
               endcase
            end
         end

         S_ACK: begin
            if (tick) begin
               q_nxt = q + 2'd1;
               case (q)
                  2'd0: sda_nxt  = 1'b0;
                  2'd1: scl_nxt  = 1'b0;
                  2'd2: nack_nxt = sda_sync[1];
                  default: begin
                     scl_nxt = 1'b1;
                     if (nack || byte_n == 2'd2) begin
                        state_nxt = S_STOP;
                     end else begin
                        byte_nxt  = byte_n + 2'd1;
                        bit_nxt   = 3'd7;
                        state_nxt = S_BIT;
                     end
                  end
               endcase
            end
         end

         S_STOP: begin
            if (tick) begin
               case (q)
                  2'd0: begin
                     sda_nxt = 1'b1;
                     q_nxt   = 2'd1;
                  end
                  2'd1: begin
                     scl_nxt = 1'b0;
                     q_nxt   = 2'd2;
                  end
                  default: begin
                     sda_nxt = 1'b0;
                     q_nxt   = 2'd0;
                     if (nack || idx_r == 3'd4) begin
                        state_nxt = S_FIN;
                     end else begin
                        gap_nxt   = GW'(GAP - 1);
                        state_nxt = S_GAP;
                     end
                  end
               endcase
            end
         end

         S_GAP: begin
            if (gap_cnt == '0) begin
               idx_nxt   = idx_r + 3'd1;
               q_nxt     = 2'd0;
               state_nxt = S_START;
            end else begin
               gap_nxt = gap_cnt - GW'(1);
            end
         end

         S_FIN: begin
            busy_nxt  = 1'b0;
            done_nxt  = ~nack;
            err_nxt   = nack;
            state_nxt = S_IDLE;
         end

         default: state_nxt = S_IDLE;
      endcase
   end

   assign bus.scl_oe = scl_r;
   assign bus.sda_oe = sda_r;
   assign bus.busy   = busy_r;
   assign bus.done   = done_r;
   assign bus.err    = err_r;
   assign bus.idx    = idx_r;
endmodule

// File: tb/tb_codec_init_seq.sv
// Bench for codec_init_seq: an I2C slave model decodes bus traffic into frames that a
// monitor pops against frames predicted from the register table.
module tb_codec_init_seq;
   localparam int QDIV      = 5;
   localparam int GAP       = 37;
   localparam int PER_WRITE = 113 * QDIV + GAP;
   localparam int BUDGET    = 5 * (PER_WRITE + 2 * QDIV) + 200;

   logic clk = 1'b0;
   logic reset;
   logic slave_pull = 1'b0;
   always #5 clk = ~clk;

   codec_init_seq_if bus();
   assign bus.sda_in = ~(bus.sda_oe | slave_pull);

   codec_init_seq #(.QDIV(QDIV), .GAP(GAP), .ADDR(7'h1A)) dut (
      .clk(clk),
      .reset(reset),
      .bus(bus)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: register/value pairs and their I2C byte images.
   int reg_tab[5] = '{8, 6, 7, 9, 2};
   int dat_tab[5] = '{'h23, 'h00, 'h40, 'h01, 'h17F};

   function automatic logic [25:0] frame_exp(input int i, input int nbytes);
      int b0, b1, b2;
      logic [23:0] v;
      b0 = 'h1A * 2;
      b1 = (reg_tab[i] * 2 + dat_tab[i] / 256) % 256;
      b2 = dat_tab[i] % 256;
      v  = {b0[7:0], b1[7:0], b2[7:0]};
      if (nbytes < 3) v[7:0]  = 8'h00;
      if (nbytes < 2) v[15:8] = 8'h00;
      return {2'(nbytes), v};
   endfunction

   logic [25:0] exp_q[$];

   bit   slave_present = 1'b1;
   int   nack_idx      = 5;
   int   nack_byte     = 0;
   int   frame_no      = 0;

   // Slave model / monitor
   bit          scl_p = 1'b1, sda_p = 1'b1;
   bit          in_frame = 1'b0, rise_seen = 1'b0, fall_seen = 1'b0;
   int          bitcnt = 0, nbytes = 0, frame_cur = 0, cyc = 0, t_rise = 0, t_fall = 0;
   logic [7:0]  shreg = 8'h00;
   logic [23:0] got = 24'h0;

   always @(negedge clk) begin
      bit scl, sda, nack_now;
      logic [25:0] e;
      cyc++;
      if (reset) begin
         in_frame   = 1'b0;
         slave_pull = 1'b0;
         scl_p      = 1'b1;
         sda_p      = 1'b1;
      end else begin
         scl = ~bus.scl_oe;
         sda = bus.sda_in;
         if (scl_p && scl && sda_p && !sda) begin
            if (in_frame) check("repeated_start", 32'(bitcnt), 32'hFFFF);
            in_frame  = 1'b1;
            bitcnt    = 0;
            nbytes    = 0;
            got       = 24'h0;
            rise_seen = 1'b0;
            fall_seen = 1'b0;
            frame_cur = frame_no;
            frame_no++;
         end else if (scl_p && scl && !sda_p && sda) begin
            if (in_frame) begin
               if (exp_q.size() == 0) begin
                  check("unexpected_frame", {6'd0, 2'(nbytes), got}, 32'h0);
               end else begin
                  e = exp_q.pop_front();
                  check("frame_bytes", {6'd0, 2'(nbytes), got}, {6'd0, e});
               end
            end
            in_frame = 1'b0;
         end else if (in_frame && !scl_p && scl) begin
            if (fall_seen) check("scl_low_cycles", 32'(cyc - t_fall), 32'(2 * QDIV));
            rise_seen = 1'b1;
            t_rise    = cyc;
            if (bitcnt < 8) shreg = {shreg[6:0], sda};
            bitcnt++;
         end else if (in_frame && scl_p && !scl) begin
            if (rise_seen) check("scl_high_cycles", 32'(cyc - t_rise), 32'(2 * QDIV));
            fall_seen = 1'b1;
            t_fall    = cyc;
            if (bitcnt == 8) begin
               if (nbytes < 3) got[(2 - nbytes) * 8 +: 8] = shreg;
               nack_now   = !slave_present || (frame_cur == nack_idx && nbytes == nack_byte);
               slave_pull = !nack_now;
               nbytes++;
            end else if (bitcnt == 9) begin
               slave_pull = 1'b0;
               bitcnt     = 0;
            end
         end
         scl_p = scl;
         sda_p = sda;
      end
   end

   task automatic push_expected(input int ni, input int nb);
      for (int i = 0; i < 5; i++) begin
         if (i < ni) exp_q.push_back(frame_exp(i, 3));
         else if (i == ni) exp_q.push_back(frame_exp(i, nb + 1));
      end
   endtask

   task automatic pulse_start();
      repeat ($urandom_range(1, 20)) @(negedge clk);
      bus.start = 1'b1;
      @(negedge clk);
      bus.start = 1'b0;
      check("busy_after_start", bus.busy, 1'b1);
      check("done_cleared", bus.done, 1'b0);
      check("err_cleared", bus.err, 1'b0);
   endtask

   // ni = index of the NACKed write (5 = none), nb = NACKed byte, sp = cycle of a spurious start
   task automatic run_seq(input int ni, input int nb, input bit present, input int sp);
      int c;
      slave_present = present;
      nack_idx      = ni;
      nack_byte     = nb;
      frame_no      = 0;
      push_expected(ni, nb);
      pulse_start();
      c = 0;
      while (!bus.sda_oe && c < 3 * QDIV) begin
         @(negedge clk);
         c++;
      end
      check("start_latency_ok", 32'(c >= QDIV - 1 && c <= QDIV + 1), 32'd1);
      c = 0;
      while (bus.busy && c < BUDGET) begin
         @(negedge clk);
         bus.start = (c == sp);
         c++;
      end
      bus.start = 1'b0;
      check("busy_drop", bus.busy, 1'b0);
      check("done", bus.done, (ni == 5) ? 1'b1 : 1'b0);
      check("err", bus.err, (ni == 5) ? 1'b0 : 1'b1);
      check("idx", bus.idx, (ni == 5) ? 32'd4 : 32'(ni));
      check("scl_released", bus.scl_oe, 1'b0);
      check("sda_released", bus.sda_oe, 1'b0);
      repeat (3) @(negedge clk);
      check("frames_left", exp_q.size(), 0);
      exp_q.delete();
   endtask

   task automatic reset_mid_write();
      int c;
      slave_present = 1'b1;
      nack_idx      = 5;
      frame_no      = 0;
      push_expected(3, 2);
      void'(exp_q.pop_back());
      pulse_start();
      c = 0;
      while (!(frame_no == 4 && bitcnt == 3) && c < BUDGET) begin
         @(negedge clk);
         c++;
      end
      check("reached_idx3_bit", bus.idx, 3);
      repeat ($urandom_range(0, 15)) @(negedge clk);
      #1 reset = 1'b1;
      #1;
      check("rst_scl_released", bus.scl_oe, 1'b0);
      check("rst_sda_released", bus.sda_oe, 1'b0);
      check("rst_busy", bus.busy, 1'b0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      check("rst_idx", bus.idx, 0);
      check("rst_done", bus.done, 1'b0);
      check("frames_before_reset", exp_q.size(), 0);
      exp_q.delete();
   endtask

   initial begin
      #900000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int ni, nb, sp;
      reset     = 1'b1;
      bus.start = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_scl", bus.scl_oe, 1'b0);
      check("reset_sda", bus.sda_oe, 1'b0);
      check("reset_busy", bus.busy, 1'b0);
      check("reset_done", bus.done, 1'b0);
      check("reset_err", bus.err, 1'b0);
      check("reset_idx", bus.idx, 0);
      reset = 1'b0;
      repeat (2) @(negedge clk);

      run_seq(5, 0, 1'b1, -1);
      run_seq(2, 1, 1'b1, -1);
      run_seq(0, 0, 1'b0, -1);
      run_seq(5, 0, 1'b1, PER_WRITE + $urandom_range(0, PER_WRITE - 1));
      reset_mid_write();
      run_seq(5, 0, 1'b1, -1);

      for (int k = 0; k < 4; k++) begin
         ni = $urandom_range(0, 5);
         nb = $urandom_range(0, 2);
         sp = ($urandom_range(0, 1) == 1) ? $urandom_range(0, PER_WRITE * 3) : -1;
         run_seq(ni, nb, 1'b1, sp);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
